// File: rtl/ryg_light_monitor.sv
// Receiving-end monitor for the red/yellow/green lamp interface: locks onto the
// phase sequence, tracks dwell per phase and flags encoding, order and length faults.
module ryg_light_monitor #(
   parameter int RED_CYC = 21,
   parameter int YEL_CYC = 31,
   parameter int GRN_CYC = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       r,
   input  logic       y,
   input  logic       g,
   input  logic       clr_err,
   output logic [1:0] phase,
   output logic [5:0] remain,
   output logic       locked,
   output logic [7:0] cyc_cnt,
   output logic       err_onehot,
   output logic       err_order,
   output logic       err_len
);

   typedef enum logic {SYNC, TRACK} state_t;

   localparam logic [1:0] L_NONE = 2'd0;
   localparam logic [1:0] L_RED  = 2'd1;
   localparam logic [1:0] L_YEL  = 2'd2;
   localparam logic [1:0] L_GRN  = 2'd3;

   function automatic logic [5:0] exp_of(input logic [1:0] l);
      case (l)
         L_RED:   return 6'(RED_CYC);
         L_YEL:   return 6'(YEL_CYC);
         L_GRN:   return 6'(GRN_CYC);
         default: return 6'd0;
      endcase
   endfunction

   function automatic logic [5:0] sat_inc6(input logic [5:0] a);
      return (a == 6'd63) ? 6'd63 : a + 6'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] a);
      return (a == 8'd255) ? 8'd255 : a + 8'd1;
   endfunction

   function automatic logic [5:0] sat_sub6(input logic [5:0] a, input logic [5:0] b);
      return (a > b) ? a - b : 6'd0;
   endfunction

   function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
      return (from == L_RED && to == L_YEL) ||
             (from == L_YEL && to == L_GRN) ||
             (from == L_GRN && to == L_RED);
   endfunction

   state_t     state, state_n;
   logic [1:0] prev, prev_n;
   logic [5:0] dwell, dwell_n;
   logic [1:0] phase_n;
   logic [5:0] remain_n;
   logic       locked_n;
   logic [7:0] cyc_n;
   logic       det_oh, det_ord, det_len;
   logic       valid;
   logic [1:0] cur;
   logic [5:0] dwell_inc;
   logic       drop, enter;

   assign valid     = (r ^ y ^ g) & ~(r & y & g);
   assign cur       = r ? L_RED : (y ? L_YEL : L_GRN);
   assign dwell_inc = sat_inc6(dwell);

   always_comb begin
      state_n  = state;
      prev_n   = prev;
      dwell_n  = dwell;
      phase_n  = phase;
      remain_n = remain;
      locked_n = locked;
      cyc_n    = cyc_cnt;
      det_oh   = 1'b0;
      det_ord  = 1'b0;
      det_len  = 1'b0;
      drop     = 1'b0;
      enter    = 1'b0;

      if (!valid) begin
         det_oh  = 1'b1;
         drop    = 1'b1;
         prev_n  = L_NONE;
         dwell_n = 6'd0;
      end else if (cur == prev) begin
         dwell_n = dwell_inc;
         if (state == TRACK) begin
            if (dwell_inc == exp_of(cur) + 6'd1) begin
               det_len = 1'b1;
               drop    = 1'b1;
            end else begin
               remain_n = sat_sub6(exp_of(cur), dwell_inc);
            end
         end
      end else begin
         prev_n  = cur;
         dwell_n = 6'd1;
         if (state == SYNC) begin
            // First change between two valid lights is the lock point.
            if (prev != L_NONE) enter = 1'b1;
         end else if (!legal_step(prev, cur)) begin
            det_ord = 1'b1;
            drop    = 1'b1;
         end else if (dwell != exp_of(prev)) begin
            det_len = 1'b1;
            drop    = 1'b1;
         end else begin
            enter = 1'b1;
            if (prev == L_GRN) cyc_n = sat_inc8(cyc_cnt);
         end
      end

      if (enter) begin
         state_n  = TRACK;
         phase_n  = cur;
         remain_n = sat_sub6(exp_of(cur), 6'd1);
         locked_n = 1'b1;
      end
      if (drop) begin
         state_n  = SYNC;
         phase_n  = 2'd0;
         remain_n = 6'd0;
         locked_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SYNC;
         prev       <= L_NONE;
         dwell      <= 6'd0;
         phase      <= 2'd0;
         remain     <= 6'd0;
         locked     <= 1'b0;
         cyc_cnt    <= 8'd0;
         err_onehot <= 1'b0;
         err_order  <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         state      <= state_n;
         prev       <= prev_n;
         dwell      <= dwell_n;
         phase      <= phase_n;
         remain     <= remain_n;
         locked     <= locked_n;
         cyc_cnt    <= cyc_n;
         // A fault detected on this edge wins over a simultaneous clear.
         err_onehot <= det_oh  | (err_onehot & ~clr_err);
         err_order  <= det_ord | (err_order  & ~clr_err);
         err_len    <= det_len | (err_len    & ~clr_err);
      end
   end

endmodule

// File: tb/tb_ryg_light_monitor.sv
// Directed bench for ryg_light_monitor: table of {stimulus, repeat, expected}
// rows plus hand-written sequences for clear/error collision and mid-run reset.
module tb_ryg_light_monitor;

   logic       clk = 1'b0;
   logic       rst, r, y, g, clr_err;
   logic [1:0] phase;
   logic [5:0] remain;
   logic       locked;
   logic [7:0] cyc_cnt;
   logic       err_onehot, err_order, err_len;

   int passed = 0;
   int total  = 0;

   localparam logic [2:0] R  = 3'b100;
   localparam logic [2:0] Y  = 3'b010;
   localparam logic [2:0] G  = 3'b001;
   localparam logic [2:0] RY = 3'b110;
   localparam logic [2:0] NO = 3'b000;

   typedef struct {
      string      name;
      logic [2:0] ryg;
      logic       clr;
      logic       rst;
      int         n;
      logic [1:0] ph;
      logic [5:0] rem;
      logic       lk;
      logic [7:0] cyc;
      logic [2:0] err;
   } vec_t;

   vec_t tbl[$];

   ryg_light_monitor #(.RED_CYC(21), .YEL_CYC(31), .GRN_CYC(11)) dut (
      .clk(clk), .rst(rst), .r(r), .y(y), .g(g), .clr_err(clr_err),
      .phase(phase), .remain(remain), .locked(locked), .cyc_cnt(cyc_cnt),
      .err_onehot(err_onehot), .err_order(err_order), .err_len(err_len)
   );

   always #5 clk = ~clk;

   function automatic void add(input string name, input logic [2:0] ryg, input logic clr,
                               input logic rs, input int n, input logic [1:0] ph,
                               input logic [5:0] rem, input logic lk, input logic [7:0] cyc,
                               input logic [2:0] err);
      vec_t v;
      v.name = name; v.ryg = ryg; v.clr = clr; v.rst = rs; v.n = n;
      v.ph = ph; v.rem = rem; v.lk = lk; v.cyc = cyc; v.err = err;
      tbl.push_back(v);
   endfunction

   task automatic step(input logic [2:0] ryg, input logic clr, input logic rs);
      @(negedge clk);
      {r, y, g} = ryg;
      clr_err   = clr;
      rst       = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] ph, input logic [5:0] rem,
                        input logic lk, input logic [7:0] cyc, input logic [2:0] err);
      total++;
      if ({phase, remain, locked, cyc_cnt, err_onehot, err_order, err_len} !==
          {ph, rem, lk, cyc, err}) begin
         $display("FAIL %s: got ph=%0d rem=%0d lk=%0d cyc=%0d err(oh,ord,len)=%b%b%b, want ph=%0d rem=%0d lk=%0d cyc=%0d err=%b",
                  name, phase, remain, locked, cyc_cnt, err_onehot, err_order, err_len,
                  ph, rem, lk, cyc, err);
      end else begin
         passed++;
      end
   endtask

   initial begin
      rst = 1'b1; {r, y, g} = R; clr_err = 1'b0;

      // Plan 1: lock on first yellow, three full rounds, then five reds.
      add("reset",        R, 0, 1,  2, 0,  0, 0, 0, 3'b000);
      add("sync_red21",   R, 0, 0, 21, 0,  0, 0, 0, 3'b000);
      add("lock_yel1",    Y, 0, 0,  1, 2, 30, 1, 0, 3'b000);
      add("yel31",        Y, 0, 0, 30, 2,  0, 1, 0, 3'b000);
      add("grn1",         G, 0, 0,  1, 3, 10, 1, 0, 3'b000);
      add("grn11",        G, 0, 0, 10, 3,  0, 1, 0, 3'b000);
      add("red1_cyc1",    R, 0, 0,  1, 1, 20, 1, 1, 3'b000);
      add("red21",        R, 0, 0, 20, 1,  0, 1, 1, 3'b000);
      add("yel_r2",       Y, 0, 0, 31, 2,  0, 1, 1, 3'b000);
      add("grn_r2",       G, 0, 0, 11, 3,  0, 1, 1, 3'b000);
      add("red1_cyc2",    R, 0, 0,  1, 1, 20, 1, 2, 3'b000);
      add("red_r3",       R, 0, 0, 20, 1,  0, 1, 2, 3'b000);
      add("yel_r3",       Y, 0, 0, 31, 2,  0, 1, 2, 3'b000);
      add("grn_r3",       G, 0, 0, 11, 3,  0, 1, 2, 3'b000);
      // Third G->R transition completes the third locked cycle.
      add("red5_rem16",   R, 0, 0,  5, 1, 16, 1, 3, 3'b000);
      // Plan 2: short yellow.
      add("red_fill",     R, 0, 0, 16, 1,  0, 1, 3, 3'b000);
      add("yel30",        Y, 0, 0, 30, 2,  1, 1, 3, 3'b000);
      add("short_yel",    G, 0, 0,  1, 0,  0, 0, 3, 3'b001);
      add("grn_sync",     G, 0, 0, 10, 0,  0, 0, 3, 3'b001);
      add("relock_red",   R, 0, 0,  1, 1, 20, 1, 3, 3'b001);
      // Plan 3: long green, after clearing the flag.
      add("clr_len",      R, 1, 0,  1, 1, 19, 1, 3, 3'b000);
      add("red_p3",       R, 0, 0, 19, 1,  0, 1, 3, 3'b000);
      add("yel_p3",       Y, 0, 0, 31, 2,  0, 1, 3, 3'b000);
      add("grn11_p3",     G, 0, 0, 11, 3,  0, 1, 3, 3'b000);
      add("long_grn",     G, 0, 0,  1, 0,  0, 0, 3, 3'b001);
      add("relock_p4",    R, 0, 0,  1, 1, 20, 1, 3, 3'b001);
      add("clr_p4",       R, 1, 0,  1, 1, 19, 1, 3, 3'b000);
      // Plan 4: two lamps at once while locked in red.
      add("onehot_ry",   RY, 0, 0,  1, 0,  0, 0, 3, 3'b100);
      // Plan 5: R->G after a full red.
      add("clr_oh",       R, 1, 0,  1, 0,  0, 0, 3, 3'b000);
      add("red_sync",     R, 0, 0,  2, 0,  0, 0, 3, 3'b000);
      add("lock_p5",      Y, 0, 0,  1, 2, 30, 1, 3, 3'b000);
      add("yel_p5",       Y, 0, 0, 30, 2,  0, 1, 3, 3'b000);
      add("grn_p5",       G, 0, 0, 11, 3,  0, 1, 3, 3'b000);
      add("red21_p5",     R, 0, 0, 21, 1,  0, 1, 4, 3'b000);
      add("order_rg",     G, 0, 0,  1, 0,  0, 0, 4, 3'b010);
      // Build an err_len for plan 6: lock on red, leave it after one sample.
      add("relock_p6",    R, 0, 0,  1, 1, 20, 1, 4, 3'b010);
      add("short_red",    Y, 0, 0,  1, 0,  0, 0, 4, 3'b011);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) step(tbl[i].ryg, tbl[i].clr, tbl[i].rst);
         check(tbl[i].name, tbl[i].ph, tbl[i].rem, tbl[i].lk, tbl[i].cyc, tbl[i].err);
      end

      // Plan 6: clear collides with a fresh one-hot fault (all lamps dark).
      step(NO, 1'b1, 1'b0);
      check("clr_vs_onehot", 2'd0, 6'd0, 1'b0, 8'd4, 3'b100);
      step(G, 1'b0, 1'b0);
      step(R, 1'b0, 1'b0);
      check("relock_p6b", 2'd1, 6'd20, 1'b1, 8'd4, 3'b100);
      step(R, 1'b0, 1'b0);
      step(R, 1'b0, 1'b0);
      step(R, 1'b1 ^ 1'b1, 1'b1);
      check("rst_mid_red", 2'd0, 6'd0, 1'b0, 8'd0, 3'b000);
      step(R, 1'b0, 1'b0);
      check("post_rst_sync", 2'd0, 6'd0, 1'b0, 8'd0, 3'b000);
      // Lamps all on: invalid even though r is high.
      step(3'b111, 1'b0, 1'b0);
      check("onehot_all", 2'd0, 6'd0, 1'b0, 8'd0, 3'b100);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
